// File: rtl/mrf_pkg.sv
// ---------------------------------------------------------------------------
// mrf_pkg
// Shared types and defaults for the mRF register-file word datapath.
//   mrf_seq_state_t : load sequencer states (IDLE, CLEAR, LOAD, DONE)
//   mrf_count_w     : width of a word counter able to hold 0..ch*num
//   MRF_*           : default geometry used by the sequencer blocks
// ---------------------------------------------------------------------------
package mrf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } mrf_seq_state_t;

    localparam int MRF_WORDWIDTH = 32;
    localparam int MRF_NUM1      = 5;
    localparam int MRF_CHANNEL   = 6;

    // The counter must reach the full word total, so it needs room for
    // ch*num itself, not just ch*num-1.
    function automatic int mrf_count_w(input int ch, input int num);
        return $clog2(ch * num + 1);
    endfunction

endpackage

// File: rtl/mrf_idx_cnt.sv
// ---------------------------------------------------------------------------
// mrf_idx_cnt
// Nested element/channel position counter for one load frame.
// Ports:
//   clk   in   clock, all logic on posedge
//   rst   in   synchronous active-high reset
//   clr   in   return to position (0,0)
//   inc   in   advance one word position
//   el    out  element index of the current word (0..NUM1-1)
//   ch    out  channel index of the current word (0..CHANNEL-1)
//   last  out  high when the current position is the final word of a frame
// ---------------------------------------------------------------------------
module mrf_idx_cnt
    import mrf_pkg::*;
#(
    parameter  int NUM1    = MRF_NUM1,
    parameter  int CHANNEL = MRF_CHANNEL,
    localparam int EL_W    = (NUM1 > 1) ? $clog2(NUM1) : 1,
    localparam int CH_W    = (CHANNEL > 1) ? $clog2(CHANNEL) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    output logic [EL_W-1:0] el,
    output logic [CH_W-1:0] ch,
    output logic            last
);

    logic [EL_W-1:0] r_el;
    logic [CH_W-1:0] r_ch;
    logic            w_elWrap;
    logic            w_chWrap;

    assign w_elWrap = (r_el == EL_W'(NUM1 - 1));
    assign w_chWrap = (r_ch == CH_W'(CHANNEL - 1));

    // Element counts fastest; its wrap carries into the channel counter,
    // which gives k/NUM1 and k%NUM1 without a divider.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_el <= '0;
            r_ch <= '0;
        end else if (inc) begin
            if (w_elWrap) begin
                r_el <= '0;
                r_ch <= w_chWrap ? '0 : r_ch + CH_W'(1);
            end else begin
                r_el <= r_el + EL_W'(1);
            end
        end
    end

    assign el   = r_el;
    assign ch   = r_ch;
    assign last = w_elWrap && w_chWrap;

endmodule

// File: rtl/mrf_load_seq.sv
// ---------------------------------------------------------------------------
// mrf_load_seq
// Load sequencer for the mRF register-file slice. A start pulse opens a frame
// of CHANNEL*NUM1 words taken from an upstream valid/ready source; the slice
// first sees one clear beat (count 0), then every word with its 1-based count.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             frame request, only honoured in IDLE
//   abort             cancel the running frame
//   in_valid/in_data  upstream word stream
//   in_ready          upstream ready (LOAD and no abort)
//   rf_count/rf_data  registered count and word towards the RF slice
//   rf_we             one-cycle write pulse per accepted word
//   ch_idx/el_idx     position of the last accepted word
//   busy              high in CLEAR and LOAD
//   done              one-cycle pulse once the frame has completed
//   stall_cnt         (only with MRF_LOAD_SEQ_STALL_CNT_EN) LOAD cycles
//                     without in_valid, saturating
// Configuration macro: MRF_LOAD_SEQ_STALL_CNT_EN
// ---------------------------------------------------------------------------
module mrf_load_seq
    import mrf_pkg::*;
#(
    parameter  int WORDWIDTH = MRF_WORDWIDTH,
    parameter  int NUM1      = MRF_NUM1,
    parameter  int CHANNEL   = MRF_CHANNEL,
    localparam int COUNT_W   = mrf_count_w(CHANNEL, NUM1),
    localparam int EL_W      = (NUM1 > 1) ? $clog2(NUM1) : 1,
    localparam int CH_W      = (CHANNEL > 1) ? $clog2(CHANNEL) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_valid,
    input  logic [WORDWIDTH-1:0] in_data,
    output logic                 in_ready,
    output logic [COUNT_W-1:0]   rf_count,
    output logic [WORDWIDTH-1:0] rf_data,
    output logic                 rf_we,
    output logic [CH_W-1:0]      ch_idx,
    output logic [EL_W-1:0]      el_idx,
    output logic                 busy,
    output logic                 done
`ifdef MRF_LOAD_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    mrf_seq_state_t r_state;
    mrf_seq_state_t w_nextState;

    logic [COUNT_W-1:0]   r_count;
    logic [WORDWIDTH-1:0] r_data;
    logic                 r_we;
    logic [CH_W-1:0]      r_chIdx;
    logic [EL_W-1:0]      r_elIdx;
    logic                 r_done;

    logic                 w_inReady;
    logic                 w_handshake;
    logic [EL_W-1:0]      w_el;
    logic [CH_W-1:0]      w_ch;
    logic                 w_last;
    logic                 w_clrIdx;

    assign w_inReady   = (r_state == LOAD) && !abort;
    assign w_handshake = in_valid && w_inReady;
    assign w_clrIdx    = (r_state == CLEAR);

    mrf_idx_cnt #(
        .NUM1    (NUM1),
        .CHANNEL (CHANNEL)
    ) u_idxCnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clrIdx),
        .inc  (w_handshake),
        .el   (w_el),
        .ch   (w_ch),
        .last (w_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. abort overrides everything except reset, including
    // a start arriving in the same IDLE cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start && !abort) w_nextState = CLEAR;
            CLEAR:   w_nextState = abort ? IDLE : LOAD;
            LOAD: begin
                if (abort) begin
                    w_nextState = IDLE;
                end else if (w_handshake && w_last) begin
                    w_nextState = DONE;
                end
            end
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Output registers. rf_count tracks the number of accepted words, so the
    // next count is simply the current one plus one; it is left at the frame
    // total after completion and only cleared by the next CLEAR beat or abort.
    // done is registered from the DONE state, so it appears one cycle after
    // the final word reaches the slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_chIdx <= '0;
            r_elIdx <= '0;
            r_done  <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                CLEAR: begin
                    r_count <= '0;
                    if (!abort) r_data <= '0;
                end
                LOAD: begin
                    if (abort) begin
                        r_count <= '0;
                    end else if (w_handshake) begin
                        r_data  <= in_data;
                        r_we    <= 1'b1;
                        r_count <= r_count + COUNT_W'(1);
                        r_chIdx <= w_ch;
                        r_elIdx <= w_el;
                    end
                end
                DONE: begin
                    if (abort) begin
                        r_count <= '0;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MRF_LOAD_SEQ_STALL_CNT_EN
    logic [15:0] r_stallCnt;

    // Counts LOAD cycles with no upstream word. Cleared when a new frame
    // enters CLEAR so the previous frame's value stays readable until then.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if ((r_state == IDLE) && (w_nextState == CLEAR)) begin
            r_stallCnt <= '0;
        end else if ((r_state == LOAD) && !in_valid && (r_stallCnt != 16'hFFFF)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end

    assign stall_cnt = r_stallCnt;
`endif

    assign in_ready = w_inReady;
    assign rf_count = r_count;
    assign rf_data  = r_data;
    assign rf_we    = r_we;
    assign ch_idx   = r_chIdx;
    assign el_idx   = r_elIdx;
    assign busy     = (r_state == CLEAR) || (r_state == LOAD);
    assign done     = r_done;

endmodule

// File: tb/tb_mrf_load_seq.sv
// ---------------------------------------------------------------------------
// tb_mrf_load_seq
// Directed self-checking bench for mrf_load_seq with default geometry
// (NUM1=5, CHANNEL=6, 30 words per frame). Stall counter checks are compiled
// in only when MRF_LOAD_SEQ_STALL_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_mrf_load_seq;

    localparam int NUM1  = 5;
    localparam int TOTAL = 30;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [4:0]  rf_count;
    logic [31:0] rf_data;
    logic        rf_we;
    logic [2:0]  ch_idx;
    logic [2:0]  el_idx;
    logic        busy;
    logic        done;
`ifdef MRF_LOAD_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int          passCount;
    int          checkCount;
    logic [31:0] expData;

    mrf_load_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rf_count (rf_count),
        .rf_data  (rf_data),
        .rf_we    (rf_we),
        .ch_idx   (ch_idx),
        .el_idx   (el_idx),
        .busy     (busy),
        .done     (done)
`ifdef MRF_LOAD_SEQ_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wordOf(input int k);
        return 32'h5A00_0000 + 32'(k) * 32'h0001_0003;
    endfunction

    task automatic applyStimulus(input logic iStart, input logic iAbort,
                                 input logic iValid, input logic [31:0] iData);
        start    = iStart;
        abort    = iAbort;
        in_valid = iValid;
        in_data  = iData;
    endtask

    // Advance one clock and sample just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_count"}, 64'(rf_count), 64'd0);
        checkOutput({tag, "_data"},  64'(rf_data),  64'd0);
        checkOutput({tag, "_we"},    64'(rf_we),    64'd0);
        checkOutput({tag, "_ch"},    64'(ch_idx),   64'd0);
        checkOutput({tag, "_el"},    64'(el_idx),   64'd0);
        checkOutput({tag, "_busy"},  64'(busy),     64'd0);
        checkOutput({tag, "_done"},  64'(done),     64'd0);
        checkOutput({tag, "_ready"}, 64'(in_ready), 64'd0);
    endtask

    // Start pulse, then the CLEAR beat: afterwards the sequencer sits in LOAD.
    task automatic startFrame(input string tag);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput({tag, "_clr_busy"},  64'(busy),     64'd1);
        checkOutput({tag, "_clr_ready"}, 64'(in_ready), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput({tag, "_clr_count"}, 64'(rf_count), 64'd0);
        checkOutput({tag, "_clr_we"},    64'(rf_we),    64'd0);
        checkOutput({tag, "_load_ready"}, 64'(in_ready), 64'd1);
    endtask

    // Offer word k for one cycle and check it lands on the RF side.
    task automatic sendWord(input int k, input logic iStart);
        applyStimulus(iStart, 1'b0, 1'b1, wordOf(k));
        tick();
        expData = wordOf(k);
        checkOutput($sformatf("w%0d_we", k),    64'(rf_we),    64'd1);
        checkOutput($sformatf("w%0d_count", k), 64'(rf_count), 64'(k + 1));
        checkOutput($sformatf("w%0d_data", k),  64'(rf_data),  64'(expData));
        checkOutput($sformatf("w%0d_ch", k),    64'(ch_idx),   64'(k / NUM1));
        checkOutput($sformatf("w%0d_el", k),    64'(el_idx),   64'(k % NUM1));
    endtask

    task automatic bubble(input int n, input int k);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        for (int i = 0; i < n; i++) begin
            tick();
            checkOutput($sformatf("gap%0d_%0d_we", k, i),    64'(rf_we),    64'd0);
            checkOutput($sformatf("gap%0d_%0d_count", k, i), 64'(rf_count), 64'(k));
            checkOutput($sformatf("gap%0d_%0d_data", k, i),  64'(rf_data),  64'(expData));
        end
    endtask

    // Called right after the final word: DONE cycle, then the done pulse.
    task automatic finishFrame(input string tag);
        checkOutput({tag, "_done_early"}, 64'(done),     64'd0);
        checkOutput({tag, "_done_busy"},  64'(busy),     64'd0);
        checkOutput({tag, "_done_ready"}, 64'(in_ready), 64'd0);
        tick();
        checkOutput({tag, "_done_pulse"}, 64'(done),     64'd1);
        checkOutput({tag, "_done_count"}, 64'(rf_count), 64'(TOTAL));
        checkOutput({tag, "_done_we"},    64'(rf_we),    64'd0);
        tick();
        checkOutput({tag, "_done_fall"},  64'(done),     64'd0);
        checkOutput({tag, "_idle_busy"},  64'(busy),     64'd0);
        checkOutput({tag, "_hold_count"}, 64'(rf_count), 64'(TOTAL));
    endtask

    // Directed sequence of all scenarios.
    initial begin
        passCount  = 0;
        checkCount = 0;
        expData    = '0;
        rst        = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h1234_5678);
        tick();
        tick();
        checkAllZero("por");
        rst = 1'b0;

        // Reset in the middle of a frame after 7 words.
        $display("[TB] reset mid-LOAD");
        startFrame("t1");
        for (int k = 0; k < 7; k++) sendWord(k, 1'b0);
        rst = 1'b1;
        tick();
        checkAllZero("t1_rst");
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t1_idle_busy", 64'(busy), 64'd0);

        // Full frame with in_valid held high; done lands 32 edges after start.
        $display("[TB] full frame");
        startFrame("t2");
        for (int k = 0; k < TOTAL; k++) sendWord(k, 1'b0);
        finishFrame("t2");

        // start and abort together in IDLE must stay idle.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("sa_idle_busy", 64'(busy), 64'd0);
        checkOutput("sa_idle_count", 64'(rf_count), 64'(TOTAL));

        // Bubbles after word 4, word 5 (element wrap) and before the last word.
        $display("[TB] bubbles");
        startFrame("t3");
        for (int k = 0; k < TOTAL; k++) begin
            if (k == 4 || k == 5 || k == TOTAL - 1) bubble(3, k);
            sendWord(k, 1'b0);
        end
        finishFrame("t3");
`ifdef MRF_LOAD_SEQ_STALL_CNT_EN
        checkOutput("t6_stall_9", 64'(stall_cnt), 64'd9);
`endif

        // Abort coinciding with word 12's valid.
        $display("[TB] abort");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
`ifdef MRF_LOAD_SEQ_STALL_CNT_EN
        checkOutput("t6_stall_clr", 64'(stall_cnt), 64'd0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t4_clr_count", 64'(rf_count), 64'd0);
        for (int k = 0; k < 11; k++) sendWord(k, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, wordOf(11));
        #1;
        checkOutput("t4_abort_ready", 64'(in_ready), 64'd0);
        tick();
        checkOutput("t4_abort_count", 64'(rf_count), 64'd0);
        checkOutput("t4_abort_we",    64'(rf_we),    64'd0);
        checkOutput("t4_abort_data",  64'(rf_data),  64'(wordOf(10)));
        checkOutput("t4_abort_busy",  64'(busy),     64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("t4_no_done%0d", i), 64'(done), 64'd0);
        end

        // start during LOAD and in DONE is ignored; start after DONE is taken.
        $display("[TB] start filtering");
        startFrame("t5");
        sendWord(0, 1'b0);
        sendWord(1, 1'b1);
        checkOutput("t5_load_start_busy", 64'(busy), 64'd1);
        for (int k = 2; k < TOTAL; k++) sendWord(k, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t5_done_pulse", 64'(done), 64'd1);
        checkOutput("t5_done_start_busy", 64'(busy), 64'd0);
        tick();
        checkOutput("t5_b2b_busy",  64'(busy),     64'd1);
        checkOutput("t5_b2b_done",  64'(done),     64'd0);
        checkOutput("t5_b2b_count", 64'(rf_count), 64'(TOTAL));
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t5_b2b_clr_count", 64'(rf_count), 64'd0);
        checkOutput("t5_b2b_ready",     64'(in_ready), 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("t5_abort_busy", 64'(busy), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
